// File: rtl/inst_mem_responder.sv
// Instruction-fetch bus responder: a word-addressed RAM behind a fixed-latency,
// in-order read pipeline with an outstanding-request throttle and a side load port.
module inst_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              inst_cyc_in,
    input  logic              inst_stb_in,
    input  logic [31:0]       inst_addr_in,
    output logic              inst_stall_out,
    output logic              inst_ack_out,
    output logic [31:0]       inst_data_out,
    input  logic              hold_in,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]        ram_q [2**ADDR_W];
    logic [31:0]        data_q [LATENCY];
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  word_addr;
    logic               accept;
    logic               ack;
    logic               unused_addr_bits;

    // Byte address to word index; the upper bits alias modulo the RAM depth.
    assign word_addr        = inst_addr_in[ADDR_W+1:2];
    assign unused_addr_bits = ^{inst_addr_in[31:ADDR_W+2], inst_addr_in[1:0]};

    assign ack            = valid_q[LATENCY-1];
    assign inst_ack_out   = ack;
    assign inst_data_out  = ack ? data_q[LATENCY-1] : 32'h0;
    assign inst_stall_out = ~sys_rst | hold_in | load_we | ((count_q == CNT_MAX) & ~ack);
    assign accept         = inst_cyc_in & inst_stb_in & ~inst_stall_out;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        valid_d = '0;
        count_d = '0;
        if (inst_cyc_in) begin
            valid_d = LATENCY'({valid_q, accept});
            count_d = count_q;
            case ({accept, ack})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // NOTE: RAM and data stages carry no reset; the valid bits alone qualify the data.
    always_ff @(posedge sys_clk) begin
        if (load_we) begin
            ram_q[load_addr] <= load_data;
        end
    end

    // A load stalls the bus, so a capture never coincides with a write to the same edge.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            data_q[0] <= ram_q[word_addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench: two responder configurations share one randomized stimulus
// stream and are compared every cycle against a scheduled-response reference model.
module tb_inst_mem_responder;

    localparam int AW    = 10;
    localparam int NI    = 2;
    localparam int DEPTH = 2**AW;

    logic          sys_clk;
    logic          sys_rst;
    logic          cyc, stb, hold, load_we;
    logic [31:0]   addr, load_data;
    logic [AW-1:0] load_addr;
    logic [NI-1:0] stall_w, ack_w;
    logic [31:0]   data_w [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    // Reference model: each accepted request is scheduled to appear at a fixed future cycle.
    int          lat [NI];
    int          max_out [NI];
    int          cnt [NI];
    logic        sched_v [NI][64];
    logic [31:0] sched_d [NI][64];
    logic [31:0] ram_m [DEPTH];

    inst_mem_responder #(.ADDR_W(AW), .LATENCY(2), .MAX_OUT(4)) dut_a (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .inst_cyc_in    (cyc),
        .inst_stb_in    (stb),
        .inst_addr_in   (addr),
        .inst_stall_out (stall_w[0]),
        .inst_ack_out   (ack_w[0]),
        .inst_data_out  (data_w[0]),
        .hold_in        (hold),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data)
    );

    inst_mem_responder #(.ADDR_W(AW), .LATENCY(3), .MAX_OUT(2)) dut_b (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .inst_cyc_in    (cyc),
        .inst_stb_in    (stb),
        .inst_addr_in   (addr),
        .inst_stall_out (stall_w[1]),
        .inst_ack_out   (ack_w[1]),
        .inst_data_out  (data_w[1]),
        .hold_in        (hold),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_clear(input int k);
        cnt[k] = 0;
        for (int s = 0; s < 64; s++) begin
            sched_v[k][s] = 1'b0;
        end
    endtask

    // One bus cycle: inputs are already set; check outputs, predict accepts, clock, update model.
    task automatic cycle();
        logic        exp_ack [NI];
        logic        exp_stall;
        logic        acc [NI];
        logic [31:0] exp_data;
        int          slot;
        #1;
        slot = cyc_n % 64;
        for (int k = 0; k < NI; k++) begin
            if (!sys_rst) model_clear(k);
            exp_ack[k] = sched_v[k][slot];
            exp_data   = exp_ack[k] ? sched_d[k][slot] : 32'h0;
            exp_stall  = !sys_rst || hold || load_we || (cnt[k] == max_out[k] && !exp_ack[k]);
            check($sformatf("ack[%0d]", k),   32'(ack_w[k]),   32'(exp_ack[k]));
            check($sformatf("data[%0d]", k),  data_w[k],       exp_data);
            check($sformatf("stall[%0d]", k), 32'(stall_w[k]), 32'(exp_stall));
            acc[k] = cyc && stb && !exp_stall;
        end
        @(posedge sys_clk);
        for (int k = 0; k < NI; k++) begin
            if (!sys_rst || !cyc) begin
                model_clear(k);
            end else begin
                if (exp_ack[k]) begin
                    cnt[k]--;
                    sched_v[k][slot] = 1'b0;
                end
                if (acc[k]) begin
                    cnt[k]++;
                    sched_v[k][(cyc_n + lat[k]) % 64] = 1'b1;
                    sched_d[k][(cyc_n + lat[k]) % 64] = ram_m[addr[AW+1:2]];
                end
            end
        end
        if (load_we) ram_m[load_addr] = load_data;
        cyc_n++;
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        lat[0] = 2; max_out[0] = 4;
        lat[1] = 3; max_out[1] = 2;
        for (int k = 0; k < NI; k++) model_clear(k);
        sys_rst = 1'b0; cyc = 1'b1; stb = 1'b1; hold = 1'b0; load_we = 1'b0;
        addr = 32'h0; load_addr = '0; load_data = 32'h0;
        @(negedge sys_clk);

        // Reset held with an active request, then released.
        repeat (3) cycle();
        sys_rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        cycle();

        // Fill the whole RAM so every later read has a known value.
        load_we = 1'b1;
        for (int w = 0; w < DEPTH; w++) begin
            load_addr = AW'(w);
            load_data = $urandom;
            cycle();
        end
        load_we = 1'b0;

        // Single read of a freshly loaded word.
        load_we = 1'b1; load_addr = AW'(5); load_data = 32'hDEADBEEF;
        cycle();
        load_we = 1'b0; cyc = 1'b1; stb = 1'b1; addr = 32'h14;
        cycle();
        idle(5);

        // Back-to-back burst over words 0..7.
        stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 32'(i * 4);
            cycle();
        end
        idle(5);

        // Continuous requests: the shallow configuration throttles.
        stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            addr = $urandom;
            cycle();
        end
        idle(5);

        // Abort with requests in flight, then a fresh cycle to word 2.
        stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(16 + i * 4);
            cycle();
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (4) cycle();
        cyc = 1'b1; stb = 1'b1; addr = 32'h8;
        cycle();
        idle(5);

        // Load colliding with a request: stalled, retried, returns the new word.
        stb = 1'b1; addr = 32'h1C;
        load_we = 1'b1; load_addr = AW'(7); load_data = 32'hC0FFEE11;
        cycle();
        load_we = 1'b0;
        cycle();
        idle(5);

        // Hold blocks accepts; then an aliasing address maps to word 0.
        stb = 1'b1; hold = 1'b1; addr = 32'h4;
        repeat (3) cycle();
        hold = 1'b0; addr = 32'h1000;
        cycle();
        idle(5);

        // Randomized traffic including loads, holds, aborts and mid-operation resets.
        repeat (600) begin
            sys_rst   = ($urandom_range(0, 99) != 0);
            cyc       = ($urandom_range(0, 19) != 0);
            stb       = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 9) == 0);
            load_we   = ($urandom_range(0, 9) == 0);
            load_addr = AW'($urandom_range(0, DEPTH - 1));
            load_data = $urandom;
            addr      = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63));
            cycle();
        end
        sys_rst = 1'b1; cyc = 1'b1; hold = 1'b0; load_we = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
